i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Transaction-level front end for the single-byte I2C master. Shares one master between NREQ requesters with round-robin arbitration, sequences multi-byte writes and single-byte reads, and returns per-transaction status and read data to the granted requester. It sits between the system-side command sources and the master's command/status ports, on the undivided clock.

## Interface
- NREQ, 4: number of requesters, 2..8
- MAX_LEN, 4: maximum write bytes per transaction, 1..4
- TIMEOUT_CYC, 65535: watchdog limit in clk_notdivided cycles
- clk_notdivided  in  1  controller clock, the undivided system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_rnw  in  NREQ  1 = read 1 byte, 0 = write
- req_addr  in  7*NREQ  packed 7-bit slave addresses
- req_len  in  2*NREQ  write length minus 1; ignored for reads
- req_wdata  in  8*MAX_LEN*NREQ  write bytes, byte 0 in the LSBs
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = NACK or timeout
- rsp_rdata  out  8  read byte, valid with rsp_valid
- m_start_o, m_stop_o, m_rnw_o  out  1 each  drive master start/stop/read_nwrite
- m_addr_o  out  7  to master slave address
- m_data_o  out  8  to master write data
- m_busy_i, m_error_i, m_success_i  in  1 each  master status
- m_rdata_i  in  8  master read data
- m_state_i  in  4  master state code

## Operation
- Reset: every output 0, FSM in IDLE, RR pointer 0, latched command cleared.
- All master inputs are registered once before use. Edges are detected against the previous registered value.
- FSM states and transitions:
  - IDLE -> ARB when any req_valid is high.
  - ARB: grant the first valid requester at or after the pointer, wrapping. Pulse its req_ready for 1 cycle. Latch rnw, addr, len and wdata. Set pointer = (grant+1) mod NREQ. Clear byte_idx. Go to LAUNCH.
  - LAUNCH: m_start_o = 1 until registered m_busy_i is high, then go to XFER with m_start_o = 0.
  - XFER, write: m_data_o = wdata[byte_idx]. m_stop_o = (byte_idx == len). On each rising entry of m_state_i to WAIT_ACK2, byte_idx increments if it is not the last byte.
  - XFER, read: m_stop_o = 0. m_rdata_i is captured on the rising edge of m_success_i.
  - XFER exits: a rising edge of m_success_i goes to DONE with err = 0. A rising edge of m_error_i goes to DONE with err = 1. If both rise in the same cycle, the error wins.
  - DONE: 1-cycle rsp_valid to the granted requester, with rsp_err and rsp_rdata (0 for writes). Then go to IDLE.
- m_addr_o and m_rnw_o hold the latched values from ARB through DONE.
- A requester dropping req_valid after its grant has no effect on the transaction.
- A request arriving during a transaction waits. Fairness: after requester i is served, every other pending requester is served before i again.
- rst_n asserted mid-transaction: immediate return to reset values. No response is issued. Recovering the master is the master's own reset.

## Timing
- req_valid high in IDLE → req_ready 1 cycle later (ARB) → m_start_o in the next cycle.
- DONE → IDLE → ARB: 2 cycles of turnaround between back-to-back grants.
- Master status latency is 1 registered cycle plus edge detection.
- rsp_valid and req_ready are exactly 1 cycle wide and never both high to the same requester in the same cycle.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in LAUNCH and XFER and clears in ARB.
  - When it reaches TIMEOUT_CYC, the FSM goes to DONE with err = 1 and drives m_start_o = 0 and m_stop_o = 1 for that cycle.
- I2C_ARB_TIMEOUT_EN undefined: no counter. LAUNCH and XFER wait indefinitely.

## Structure
- Package i2c_pkg holds:
  - master state codes (IDLE=0, WAIT_ACK1=4, WAIT_ACK2=6, RECEIVE=7, STOP=8, ERROR=9)
  - the controller FSM state enum
  - TIMEOUT width
- One sub-module, i2c_rr_arbiter: combinational round-robin grant from req_valid and pointer, producing a one-hot grant plus its index. The controller owns the pointer register.

## Test plan
- Single write, req0, addr 0x50, len 2, bytes 0x11,0x22,0x33 → m_data_o sequences 0x11→0x22→0x33, m_stop_o rises with byte 2, rsp_valid[0] with rsp_err = 0.
- Read, req1, addr 0x3C; model returns 0xA5 → rsp_valid[1], rsp_rdata = 0xA5, rsp_err = 0.
- NACK: model asserts m_error_i after the address → rsp_err = 1, FSM back to IDLE, next request granted.
- All 4 requesters valid continuously → grants in order 0,1,2,3,0, each with exactly one req_ready and one rsp_valid.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC = 100, m_busy_i held 0 → rsp_err = 1 at cycle 100 of LAUNCH, with a 1-cycle m_stop_o pulse.
- rst_n low mid-XFER → all outputs 0 on the next sample; no rsp_valid. After release, the pointer restarts at 0.

Source files
------------

// File: rtl/i2c_txn_arbiter_pkg.sv
// i2c_pkg: master state codes, controller FSM states, status snapshot type and watchdog width
// shared by the I2C transaction arbiter and its round-robin picker.
package i2c_pkg;

    localparam logic [3:0] MS_IDLE      = 4'd0;
    localparam logic [3:0] MS_WAIT_ACK1 = 4'd4;
    localparam logic [3:0] MS_WAIT_ACK2 = 4'd6;
    localparam logic [3:0] MS_RECEIVE   = 4'd7;
    localparam logic [3:0] MS_STOP      = 4'd8;
    localparam logic [3:0] MS_ERROR     = 4'd9;

    localparam int TO_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LAUNCH,
        ST_XFER,
        ST_DONE
    } ctrl_state_e;

    typedef struct packed {
        logic       busy;
        logic       err;
        logic       succ;
        logic [7:0] rdata;
        logic [3:0] mstate;
    } mst_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr.sv
// i2c_rr_arbiter: combinational round-robin pick of the first request at or after ptr,
// wrapping, as a one-hot grant plus its index.
import i2c_pkg::*;
module i2c_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [IW-1:0] cur;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cur     = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req[cur]) begin
                gnt_any     = 1'b1;
                gnt_idx     = cur;
                gnt_oh[cur] = 1'b1;
            end
            cur = (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one single-byte I2C master between NREQ requesters, round-robin.
// Define I2C_ARB_TIMEOUT_EN to add a watchdog that aborts LAUNCH/XFER after TIMEOUT_CYC cycles.
import i2c_pkg::*;
module i2c_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int MAX_LEN     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk_notdivided,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_rnw,
    input  logic [7*NREQ-1:0]         req_addr,
    input  logic [2*NREQ-1:0]         req_len,
    input  logic [8*MAX_LEN*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_err,
    output logic [7:0]                rsp_rdata,
    output logic                      m_start_o,
    output logic                      m_stop_o,
    output logic                      m_rnw_o,
    output logic [6:0]                m_addr_o,
    output logic [7:0]                m_data_o,
    input  logic                      m_busy_i,
    input  logic                      m_error_i,
    input  logic                      m_success_i,
    input  logic [7:0]                m_rdata_i,
    input  logic [3:0]                m_state_i
);

    localparam int IW = idx_w(NREQ);
    localparam int DW = 8 * MAX_LEN;

    ctrl_state_e     state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      addr_q, addr_d;
    logic [1:0]      len_q, len_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    mst_t            mst_q, mst_d;
    logic [2:0]      prv_q, prv_d;

    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            in_arb, launch, xfer, done, take, to_hit;
    logic            err_rise, succ_rise, ack2_rise;

    i2c_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign in_arb    = (state_q == ST_ARB);
    assign launch    = (state_q == ST_LAUNCH);
    assign xfer      = (state_q == ST_XFER);
    assign done      = (state_q == ST_DONE);
    assign take      = in_arb && gnt_any;
    // Edges compare the registered status with its one-cycle-older copy.
    assign err_rise  = mst_q.err && !prv_q[2];
    assign succ_rise = mst_q.succ && !prv_q[1];
    assign ack2_rise = (mst_q.mstate == MS_WAIT_ACK2) && !prv_q[0];

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = in_arb ? '0 : ((launch || xfer) ? cnt_q + TO_W'(1) : cnt_q);

    always_ff @(posedge clk_notdivided or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign to_hit = (launch || xfer) && (cnt_q == TO_W'(TIMEOUT_CYC));
`else
    logic [TO_W-1:0] unused_to;

    assign unused_to = TO_W'(TIMEOUT_CYC);
    assign to_hit    = 1'b0;
`endif

    always_ff @(posedge clk_notdivided or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = |req_valid ? ST_ARB : ST_IDLE;
            ST_ARB:    state_d = gnt_any ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_d = to_hit ? ST_DONE : (mst_q.busy ? ST_XFER : ST_LAUNCH);
            ST_XFER:   state_d = (to_hit || err_rise || succ_rise) ? ST_DONE : ST_XFER;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mst_d      = '{busy: m_busy_i, err: m_error_i, succ: m_success_i,
                       rdata: m_rdata_i, mstate: m_state_i};
        prv_d      = {mst_q.err, mst_q.succ, mst_q.mstate == MS_WAIT_ACK2};
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        byte_idx_d = byte_idx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (take) begin
            gnt_d      = gnt_oh;
            ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            rnw_d      = req_rnw[gnt_idx];
            addr_d     = 7'(req_addr >> (7 * int'(gnt_idx)));
            len_d      = 2'(req_len >> (2 * int'(gnt_idx)));
            wdata_d    = DW'(req_wdata >> (DW * int'(gnt_idx)));
            byte_idx_d = '0;
            rdata_d    = '0;
            err_d      = 1'b0;
        end
        if (xfer && !rnw_q && ack2_rise && byte_idx_q != len_q)
            byte_idx_d = byte_idx_q + 2'd1;
        if (xfer && rnw_q && succ_rise && !err_rise)
            rdata_d = mst_q.rdata;
        if (to_hit || (xfer && err_rise))
            err_d = 1'b1;
    end

    always_ff @(posedge clk_notdivided or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            byte_idx_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mst_q      <= '0;
            prv_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            byte_idx_q <= byte_idx_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mst_q      <= mst_d;
            prv_q      <= prv_d;
        end
    end

    // During ARB the command is shown straight from the grant mux so it is valid from ARB on.
    always_comb begin
        req_ready = in_arb ? gnt_oh : '0;
        rsp_valid = done ? gnt_q : '0;
        rsp_err   = done && err_q;
        rsp_rdata = done ? rdata_q : '0;
        m_start_o = launch && !mst_q.busy && !to_hit;
        m_stop_o  = to_hit || (xfer && !rnw_q && byte_idx_q == len_q);
        m_rnw_o   = in_arb ? rnw_d : ((state_q != ST_IDLE) && rnw_q);
        m_addr_o  = in_arb ? addr_d : ((state_q != ST_IDLE) ? addr_q : '0);
        m_data_o  = (xfer && !rnw_q) ? 8'(wdata_q >> {byte_idx_q, 3'b000}) : '0;
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: randomized requesters plus a behavioural I2C master, checked against a
// transaction-level round-robin and response model.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;

    localparam int NREQ        = 4;
    localparam int MAX_LEN     = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam logic [3:0] S_IDLE = 4'd0, S_ACK1 = 4'd4, S_DATA = 4'd5, S_ACK2 = 4'd6,
                           S_RECV = 4'd7, S_STOP = 4'd8, S_ERR = 4'd9;

    logic                      clk_notdivided = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NREQ-1:0]           req_valid, req_rnw;
    logic [7*NREQ-1:0]         req_addr;
    logic [2*NREQ-1:0]         req_len;
    logic [8*MAX_LEN*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]           req_ready, rsp_valid;
    logic                      rsp_err;
    logic [7:0]                rsp_rdata;
    logic                      m_start_o, m_stop_o, m_rnw_o;
    logic [6:0]                m_addr_o;
    logic [7:0]                m_data_o;
    logic                      m_busy_i = 1'b0, m_error_i = 1'b0, m_success_i = 1'b0;
    logic [7:0]                m_rdata_i = 8'h00;
    logic [3:0]                m_state_i = 4'h0;

    always #5 clk_notdivided = ~clk_notdivided;

    i2c_txn_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_notdivided (clk_notdivided),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_rnw        (req_rnw),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_rdata      (rsp_rdata),
        .m_start_o      (m_start_o),
        .m_stop_o       (m_stop_o),
        .m_rnw_o        (m_rnw_o),
        .m_addr_o       (m_addr_o),
        .m_data_o       (m_data_o),
        .m_busy_i       (m_busy_i),
        .m_error_i      (m_error_i),
        .m_success_i    (m_success_i),
        .m_rdata_i      (m_rdata_i),
        .m_state_i      (m_state_i)
    );

    int checks = 0, errors = 0, cyc = 0;
    bit       pend [NREQ];
    bit       rnw_m [NREQ];
    bit       keep [NREQ];
    bit [6:0] addr_m [NREQ];
    int       len_m [NREQ];
    bit [7:0] wd_m [NREQ][MAX_LEN];
    int       last = NREQ - 1;
    int       rsp_cnt = 0, rsp_idx = -1, rdy_cnt = 0, rsp_cyc = 0, rdy_cyc = 0;
    bit       rsp_e;
    bit [7:0] rsp_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Next requester to serve: first pending one strictly after the last served, wrapping.
    function automatic int rr_pick();
        for (int k = 1; k <= NREQ; k++) if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_rnw[i]          = rnw_m[i];
            req_addr[i*7 +: 7]  = addr_m[i];
            req_len[i*2 +: 2]   = 2'(len_m[i]);
            for (int b = 0; b < MAX_LEN; b++) req_wdata[(i*MAX_LEN + b)*8 +: 8] = wd_m[i][b];
        end
    endtask

    task automatic new_req(input int i, input bit rnw, input bit [6:0] a, input int len, input bit kp);
        pend[i]   = 1'b1;
        rnw_m[i]  = rnw;
        addr_m[i] = a;
        len_m[i]  = len;
        keep[i]   = kp;
        for (int b = 0; b < MAX_LEN; b++) wd_m[i][b] = 8'($urandom);
    endtask

    task automatic tick();
        @(negedge clk_notdivided);
        cyc++;
        if (rsp_valid != '0) begin
            rsp_cnt++;
            rsp_idx = idx_of(rsp_valid);
            rsp_e   = rsp_err;
            rsp_d   = rsp_rdata;
            rsp_cyc = cyc;
            check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
            check("rsp_ready_overlap", 64'(rsp_valid & req_ready), 64'd0);
        end
        if (req_ready != '0) begin
            rdy_cnt++;
            rdy_cyc = cyc;
        end
    endtask

    task automatic wait_grant(output int g);
        int n = 0;
        int exp_g = rr_pick();
        rdy_cnt = 0;
        rsp_cnt = 0;
        while (rdy_cnt == 0 && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", 64'(rdy_cnt), 64'd1);
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        g = idx_of(req_ready);
        check("grant_idx", 64'(g), 64'(exp_g));
    endtask

    // One full transaction: grant, launch, master behaviour, response.
    task automatic serve(input bit nack, input bit [7:0] rd, input bit chk_gap, output int g);
        int n, t_len, prev_rsp;
        bit t_rnw;
        bit [6:0] t_addr;
        bit [7:0] t_wd [MAX_LEN];
        prev_rsp = rsp_cyc;
        wait_grant(g);
        if (g < 0) return;
        if (chk_gap) check("turnaround", 64'(rdy_cyc - prev_rsp), 64'd2);
        last   = g;
        t_rnw  = rnw_m[g];
        t_addr = addr_m[g];
        t_len  = len_m[g];
        t_wd   = wd_m[g];
        tick();
        check("launch_start", 64'(m_start_o), 64'd1);
        check("launch_addr", 64'(m_addr_o), 64'(t_addr));
        check("launch_rnw", 64'(m_rnw_o), 64'(t_rnw));
        if (!keep[g]) pend[g] = 1'b0;
        drive_reqs();
        tick();
        m_busy_i  = 1'b1;
        m_state_i = S_ACK1;
        repeat (3) tick();
        check("start_dropped", 64'(m_start_o), 64'd0);
        if (nack) begin
            m_error_i = 1'b1;
            m_busy_i  = 1'b0;
            m_state_i = S_ERR;
            tick();
            m_error_i = 1'b0;
            m_state_i = S_IDLE;
        end else begin
            if (t_rnw) begin
                m_state_i = S_RECV;
                repeat (2) tick();
                check("rd_stop", 64'(m_stop_o), 64'd0);
                m_rdata_i = rd;
            end else begin
                for (int b = 0; b <= t_len; b++) begin
                    m_state_i = S_DATA;
                    repeat (2) tick();
                    check("wr_data", 64'(m_data_o), 64'(t_wd[b]));
                    check("wr_stop", 64'(m_stop_o), 64'(b == t_len));
                    m_state_i = S_ACK2;
                    repeat (3) tick();
                end
            end
            m_success_i = 1'b1;
            m_busy_i    = 1'b0;
            m_state_i   = S_STOP;
            tick();
            m_success_i = 1'b0;
            m_state_i   = S_IDLE;
            m_rdata_i   = 8'($urandom);
        end
        n = 0;
        while (rsp_cnt == 0 && n < 10) begin
            tick();
            n++;
        end
        check("rsp_count", 64'(rsp_cnt), 64'd1);
        check("rsp_idx", 64'(rsp_idx), 64'(g));
        check("rsp_err", 64'(rsp_e), 64'(nack));
        check("rsp_rdata", 64'(rsp_d), 64'((t_rnw && !nack) ? rd : 8'h00));
        check("ready_count", 64'(rdy_cnt), 64'd1);
    endtask

    initial begin
        int g;
        drive_reqs();
        repeat (3) tick();
        check("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, m_start_o, m_stop_o,
                                    m_rnw_o, m_addr_o, m_data_o}), 64'd0);
        rst_n = 1'b1;
        tick();

        // all requesters held valid: strict rotation from pointer 0
        for (int i = 0; i < NREQ; i++) new_req(i, $urandom_range(1, 0), 7'($urandom), $urandom_range(MAX_LEN - 1, 0), 1'b1);
        drive_reqs();
        for (int j = 0; j < 5; j++) begin
            serve(1'b0, 8'($urandom), j > 0, g);
            check("rotation", 64'(g), 64'(j % NREQ));
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        new_req(0, 1'b0, 7'h50, 2, 1'b0);
        wd_m[0][0] = 8'h11;
        wd_m[0][1] = 8'h22;
        wd_m[0][2] = 8'h33;
        drive_reqs();
        serve(1'b0, 8'h00, 1'b0, g);
        check("dir_write_grant", 64'(g), 64'd0);

        new_req(1, 1'b1, 7'h3C, 0, 1'b0);
        drive_reqs();
        serve(1'b0, 8'hA5, 1'b0, g);
        check("dir_read_grant", 64'(g), 64'd1);

        new_req(2, 1'b0, 7'h21, 1, 1'b0);
        new_req(3, 1'b1, 7'h42, 0, 1'b0);
        drive_reqs();
        serve(1'b1, 8'h00, 1'b0, g);
        check("nack_grant", 64'(g), 64'd2);
        serve(1'b0, 8'h5A, 1'b1, g);
        check("after_nack_grant", 64'(g), 64'd3);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1)
                    new_req(i, $urandom_range(1, 0), 7'($urandom), $urandom_range(MAX_LEN - 1, 0), $urandom_range(3, 0) == 0);
            if (rr_pick() < 0) new_req($urandom_range(NREQ - 1, 0), $urandom_range(1, 0), 7'($urandom), $urandom_range(MAX_LEN - 1, 0), 1'b0);
            drive_reqs();
            serve($urandom_range(4, 0) == 0, 8'($urandom), 1'b1, g);
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive_reqs();
        repeat (4) tick();

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int n = 0;
            new_req(1, 1'b0, 7'h11, 0, 1'b0);
            drive_reqs();
            wait_grant(g);
            last = 1;
            tick();
            check("to_launch_start", 64'(m_start_o), 64'd1);
            pend[1] = 1'b0;
            drive_reqs();
            while (!m_stop_o && n < 200) begin
                tick();
                n++;
            end
            check("to_cycle", 64'(n), 64'(TIMEOUT_CYC));
            check("to_start_low", 64'(m_start_o), 64'd0);
            check("to_no_early_rsp", 64'(rsp_cnt), 64'd0);
            tick();
            check("to_rsp", 64'(rsp_cnt), 64'd1);
            check("to_rsp_err", 64'(rsp_e), 64'd1);
            check("to_rsp_idx", 64'(rsp_idx), 64'd1);
            check("to_stop_pulse", 64'(m_stop_o), 64'd0);
            repeat (3) tick();
        end
`endif

        // reset in the middle of a write
        new_req(0, 1'b0, 7'h2B, 3, 1'b0);
        drive_reqs();
        wait_grant(g);
        last = g;
        tick();
        pend[0] = 1'b0;
        drive_reqs();
        tick();
        m_busy_i  = 1'b1;
        m_state_i = S_ACK1;
        repeat (3) tick();
        m_state_i = S_DATA;
        tick();
        check("pre_reset_data", 64'(m_data_o), 64'(wd_m[0][0]));
        rst_n = 1'b0;
        rsp_cnt = 0;
        m_busy_i = 1'b0;
        m_state_i = S_IDLE;
        tick();
        check("midreset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, m_start_o, m_stop_o,
                                       m_rnw_o, m_addr_o, m_data_o}), 64'd0);
        new_req(0, 1'b1, 7'h0A, 0, 1'b0);
        new_req(2, 1'b1, 7'h0B, 0, 1'b0);
        drive_reqs();
        repeat (3) tick();
        check("midreset_no_rsp", 64'(rsp_cnt), 64'd0);
        last = NREQ - 1;
        rst_n = 1'b1;
        serve(1'b0, 8'h3D, 1'b0, g);
        check("ptr_restart", 64'(g), 64'd0);
        serve(1'b0, 8'hC3, 1'b1, g);
        check("ptr_restart_next", 64'(g), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
